// File: rtl/pmem_arbiter.sv
// -----------------------------------------------------------------------------
// pmem_arbiter
//
// Shares one single-ported program memory (1-cycle synchronous read) between
// the core's instruction fetch port and a loader port. Only one transaction
// is in flight at a time.
//
// Arbitration:
//   - while ldLock is high, only the loader is granted.
//   - otherwise the CPU wins, except that a waiting loader wins once it has
//     been passed over MAX_CPU_BURST times in a row.
//
// Optional feature (macro PMEM_WRITE_VERIFY_EN):
//   When defined, every loader write is read back and compared with the
//     written data. A mismatch is reported on ldErr together with ldAck.
//   When undefined, writes are acknowledged right after the write cycle and
//     ldErr is tied low.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cpuReq/cpuAddr           core fetch request and address (PC)
//   cpuData/cpuValid         fetched instruction and one-cycle valid pulse
//   cpuHold                  core stall (programming mode or loader busy)
//   ldLock                   programming mode, loader owns memory
//   ldReq/ldWe/ldAddr/ldWData  loader request, held stable until ldAck
//   ldRData/ldAck/ldErr      loader read data, completion pulse, verify error
//   memAddr/memWe/memWData/memRData  program memory port
// -----------------------------------------------------------------------------
module pmem_arbiter #(
  parameter int PC_WIDTH      = 9,
  parameter int INST_WIDTH    = 12,
  parameter int MAX_CPU_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpuReq,
  input  logic [PC_WIDTH-1:0]   cpuAddr,
  output logic [INST_WIDTH-1:0] cpuData,
  output logic                  cpuValid,
  output logic                  cpuHold,
  input  logic                  ldLock,
  input  logic                  ldReq,
  input  logic                  ldWe,
  input  logic [PC_WIDTH-1:0]   ldAddr,
  input  logic [INST_WIDTH-1:0] ldWData,
  output logic [INST_WIDTH-1:0] ldRData,
  output logic                  ldAck,
  output logic                  ldErr,
  output logic [PC_WIDTH-1:0]   memAddr,
  output logic                  memWe,
  output logic [INST_WIDTH-1:0] memWData,
  input  logic [INST_WIDTH-1:0] memRData
);

  localparam int BURST_W = $clog2(MAX_CPU_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_CPU_BURST);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_WAIT = 2'd2
`ifdef PMEM_WRITE_VERIFY_EN
    ,
    ST_VRFY = 2'd3
`endif
  } state_t;

  state_t                state_q, state_d;
  logic                  owner_ld_q, owner_ld_d;
  logic                  we_q, we_d;
  logic [PC_WIDTH-1:0]   addr_q, addr_d;
  logic [INST_WIDTH-1:0] wdata_q, wdata_d;
  logic [BURST_W-1:0]    burst_cnt_q, burst_cnt_d;
  logic [INST_WIDTH-1:0] cpu_data_q, cpu_data_d;
  logic [INST_WIDTH-1:0] ld_rdata_q, ld_rdata_d;
  logic                  cpu_valid_q, cpu_valid_d;
  logic                  ld_ack_q, ld_ack_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  grant_cpu_s, grant_ld_s;
`ifdef PMEM_WRITE_VERIFY_EN
  logic                  ld_err_q, ld_err_d;
`endif

  // Next-state, arbitration and registered-output computation.
  always_comb begin
    state_d     = state_q;
    owner_ld_d  = owner_ld_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    burst_cnt_d = burst_cnt_q;
    cpu_data_d  = cpu_data_q;
    ld_rdata_d  = ld_rdata_q;
    cpu_valid_d = 1'b0;
    ld_ack_d    = 1'b0;
    grant_cpu_s = 1'b0;
    grant_ld_s  = 1'b0;
`ifdef PMEM_WRITE_VERIFY_EN
    ld_err_d    = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (ldLock) begin
          grant_ld_s = ldReq;
        end else if (cpuReq && !(ldReq && (burst_cnt_q == BURST_MAX))) begin
          grant_cpu_s = 1'b1;
        end else begin
          grant_ld_s = ldReq;
        end

        // Burst counter only measures CPU wins against a waiting loader.
        if (!ldReq || grant_ld_s) begin
          burst_cnt_d = {BURST_W{1'b0}};
        end else if (grant_cpu_s && (burst_cnt_q != BURST_MAX)) begin
          burst_cnt_d = burst_cnt_q + BURST_W'(1);
        end else begin
          burst_cnt_d = burst_cnt_q;
        end

        if (grant_cpu_s || grant_ld_s) begin
          state_d    = ST_ACC;
          owner_ld_d = grant_ld_s;
          we_d       = grant_ld_s & ldWe;
          addr_d     = grant_ld_s ? ldAddr : cpuAddr;
          wdata_d    = ldWData;
        end else begin
          state_d    = ST_IDLE;
        end
      end

      ST_ACC: begin
        if (we_q) begin
`ifdef PMEM_WRITE_VERIFY_EN
          state_d  = ST_VRFY;
`else
          state_d  = ST_IDLE;
          ld_ack_d = 1'b1;
`endif
        end else begin
          state_d = ST_WAIT;
        end
      end

`ifdef PMEM_WRITE_VERIFY_EN
      // Address is re-presented with memWe low so the memory reads it back.
      ST_VRFY: begin
        state_d = ST_WAIT;
      end
`endif

      ST_WAIT: begin
        state_d = ST_IDLE;
        if (owner_ld_q) begin
          ld_ack_d = 1'b1;
          if (we_q) begin
`ifdef PMEM_WRITE_VERIFY_EN
            ld_err_d = (memRData != wdata_q);
`else
            ld_rdata_d = ld_rdata_q;
`endif
          end else begin
            ld_rdata_d = memRData;
          end
        end else begin
          cpu_valid_d = 1'b1;
          cpu_data_d  = memRData;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cpu_hold_d = ldLock | ((state_d != ST_IDLE) & owner_ld_d);
  end

  // State, transaction latches and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_ld_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= {PC_WIDTH{1'b0}};
      wdata_q     <= {INST_WIDTH{1'b0}};
      burst_cnt_q <= {BURST_W{1'b0}};
      cpu_data_q  <= {INST_WIDTH{1'b0}};
      ld_rdata_q  <= {INST_WIDTH{1'b0}};
      cpu_valid_q <= 1'b0;
      ld_ack_q    <= 1'b0;
      cpu_hold_q  <= 1'b0;
`ifdef PMEM_WRITE_VERIFY_EN
      ld_err_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_ld_q  <= owner_ld_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      burst_cnt_q <= burst_cnt_d;
      cpu_data_q  <= cpu_data_d;
      ld_rdata_q  <= ld_rdata_d;
      cpu_valid_q <= cpu_valid_d;
      ld_ack_q    <= ld_ack_d;
      cpu_hold_q  <= cpu_hold_d;
`ifdef PMEM_WRITE_VERIFY_EN
      ld_err_q    <= ld_err_d;
`endif
    end
  end

  // we_q can only be set for a loader grant, so it alone qualifies the write.
  assign memWe    = (state_q == ST_ACC) & we_q;
  assign memAddr  = addr_q;
  assign memWData = wdata_q;

  assign cpuData  = cpu_data_q;
  assign cpuValid = cpu_valid_q;
  assign cpuHold  = cpu_hold_q;
  assign ldRData  = ld_rdata_q;
  assign ldAck    = ld_ack_q;
`ifdef PMEM_WRITE_VERIFY_EN
  assign ldErr    = ld_err_q;
`else
  assign ldErr    = 1'b0;
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pmem_arbiter
//
// Self-checking bench for pmem_arbiter. The bench owns a behavioural program
// memory and a reference copy of its contents.
//
// Directed scenarios cover the following:
//   - reset
//   - fetch latency
//   - programming mode
//   - burst fairness
//   - reset during a write
//   - write verify (when PMEM_WRITE_VERIFY_EN is defined)
//
// A randomized phase then checks the following against the reference:
//   - every completion
//   - the fairness bound
//   - lock exclusion
//   - stall behaviour
// -----------------------------------------------------------------------------
module tb_pmem_arbiter;

  localparam int PCW  = 9;
  localparam int IW   = 12;
  localparam int MAXB = 4;
`ifdef PMEM_WRITE_VERIFY_EN
  localparam int WR_LAT = 4;
`else
  localparam int WR_LAT = 2;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           cpuReq;
  logic [PCW-1:0] cpuAddr;
  logic [IW-1:0]  cpuData;
  logic           cpuValid;
  logic           cpuHold;
  logic           ldLock;
  logic           ldReq;
  logic           ldWe;
  logic [PCW-1:0] ldAddr;
  logic [IW-1:0]  ldWData;
  logic [IW-1:0]  ldRData;
  logic           ldAck;
  logic           ldErr;
  logic [PCW-1:0] memAddr;
  logic           memWe;
  logic [IW-1:0]  memWData;
  logic [IW-1:0]  memRData;

  // behavioural memory plus a preload port and a readback-corruption control
  logic [IW-1:0]  mem [512];
  logic [IW-1:0]  ref_mem [512];
  logic           pre_we;
  logic [PCW-1:0] pre_addr;
  logic [IW-1:0]  pre_data;
  logic           corrupt_rd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pmem_arbiter #(.PC_WIDTH(PCW), .INST_WIDTH(IW), .MAX_CPU_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .cpuReq(cpuReq), .cpuAddr(cpuAddr), .cpuData(cpuData),
    .cpuValid(cpuValid), .cpuHold(cpuHold),
    .ldLock(ldLock), .ldReq(ldReq), .ldWe(ldWe), .ldAddr(ldAddr),
    .ldWData(ldWData), .ldRData(ldRData), .ldAck(ldAck), .ldErr(ldErr),
    .memAddr(memAddr), .memWe(memWe), .memWData(memWData), .memRData(memRData)
  );

  // synchronous-read memory model
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (memWe) mem[memAddr] <= memWData;
    memRData <= corrupt_rd ? 12'h000 : mem[memAddr];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // run one loader transaction to completion; lat = cycles from drive to ack
  task automatic ld_txn(input logic we, input logic [PCW-1:0] a, input logic [IW-1:0] d,
                        output int lat, output logic err, output logic [IW-1:0] rd);
    ldReq = 1'b1; ldWe = we; ldAddr = a; ldWData = d;
    lat = 0;
    do begin tick(); lat++; end while (!ldAck && lat < 20);
    err = ldErr; rd = ldRData;
    ldReq = 1'b0; ldWe = 1'b0;
  endtask

  // run one CPU fetch to completion; lat = cycles from drive to valid
  task automatic cpu_txn(input logic [PCW-1:0] a, output int lat, output logic [IW-1:0] rd);
    cpuReq = 1'b1; cpuAddr = a;
    lat = 0;
    do begin tick(); lat++; end while (!cpuValid && lat < 20);
    rd = cpuData;
    cpuReq = 1'b0;
  endtask

  // random-phase state
  logic           cpu_busy, ld_busy, ld_w;
  logic [PCW-1:0] cpu_a, ld_a;
  logic [IW-1:0]  ld_d;
  logic           l0, l1, l2, r0, r1, r2;
  int             run, cpu_wait, ld_wait;

  function automatic logic [PCW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return PCW'($urandom);
    else return PCW'($urandom_range(0, 15));
  endfunction

  initial begin
    int            lat, c0, acks, wecnt, cv, hb, n;
    logic          err;
    logic [IW-1:0] rd, v;
    logic          seq [$];

    rst = 1'b1; cpuReq = 1'b0; cpuAddr = '0; ldLock = 1'b0; ldReq = 1'b0;
    ldWe = 1'b0; ldAddr = '0; ldWData = '0; pre_we = 1'b0; pre_addr = '0;
    pre_data = '0; corrupt_rd = 1'b0;

    // preload memory and the reference copy
    for (int i = 0; i < 512; i++) begin
      v = (i == 511) ? 12'hA5C : IW'($urandom);
      ref_mem[i] = v;
      pre_we = 1'b1; pre_addr = PCW'(i); pre_data = v;
      tick();
    end
    pre_we = 1'b0;
    tick(); tick();

    // reset state
    check_val("rst_cpuData", 32'(cpuData), 32'h0);
    check_val("rst_ldRData", 32'(ldRData), 32'h0);
    check_val("rst_cpuValid", 32'(cpuValid), 32'h0);
    check_val("rst_ldAck", 32'(ldAck), 32'h0);
    check_val("rst_ldErr", 32'(ldErr), 32'h0);
    check_val("rst_cpuHold", 32'(cpuHold), 32'h0);
    check_val("rst_memWe", 32'(memWe), 32'h0);
    rst = 1'b0;
    tick();

    // fetch from the top address: valid 2 cycles after acceptance
    cpu_txn(9'h1FF, lat, rd);
    check_val("fetch_lat", 32'(lat), 32'd3);
    check_val("fetch_data", 32'(rd), 32'hA5C);
    tick();

    // programming mode: write then read back, CPU locked out
    ldLock = 1'b1; cpuReq = 1'b1; cpuAddr = 9'h010;
    tick();
    check_val("hold_lock", 32'(cpuHold), 32'd1);
    ldReq = 1'b1; ldWe = 1'b1; ldAddr = 9'h010; ldWData = 12'h123;
    acks = 0; wecnt = 0; cv = 0; hb = 0; c0 = 0;
    for (int c = 1; c <= 40 && acks < 2; c++) begin
      tick();
      if (memWe) wecnt++;
      if (cpuValid) cv++;
      if (!cpuHold) hb++;
      if (ldAck) begin
        acks++;
        if (acks == 1) begin
          check_val("prog_wr_lat", 32'(c), 32'(WR_LAT));
          check_val("prog_wr_err", 32'(ldErr), 32'd0);
          ref_mem[16] = 12'h123;
          ldWe = 1'b0;
          c0 = c;
        end else begin
          check_val("prog_rd_lat", 32'(c - c0), 32'd3);
          check_val("prog_rd_data", 32'(ldRData), 32'h123);
          ldReq = 1'b0;
        end
      end
    end
    check_val("prog_acks", 32'(acks), 32'd2);
    check_val("prog_we_pulses", 32'(wecnt), 32'd1);
    check_val("prog_cpu_grants", 32'(cv), 32'd0);
    check_val("prog_hold_drops", 32'(hb), 32'd0);
    cpuReq = 1'b0;
    tick();
    ldLock = 1'b0;
    tick(); tick();
    check_val("hold_release", 32'(cpuHold), 32'd0);

    // both requesters held high: CPU x MAXB then loader, repeating
    cpuReq = 1'b1; cpuAddr = 9'h005;
    ldReq = 1'b1; ldWe = 1'b0; ldAddr = 9'h006;
    for (int c = 0; c < 200 && seq.size() < 15; c++) begin
      tick();
      if (cpuValid) seq.push_back(1'b0);
      if (ldAck) seq.push_back(1'b1);
    end
    cpuReq = 1'b0; ldReq = 1'b0;
    check_val("burst_count", 32'(seq.size()), 32'd15);
    n = 0;
    foreach (seq[i]) begin
      check_val("grant_order", 32'(seq[i]), 32'((n % (MAXB + 1)) == MAXB));
      n++;
    end
    tick(); tick();

    // reset during the write cycle of a loader write
    ldReq = 1'b1; ldWe = 1'b1; ldAddr = 9'h020; ldWData = 12'h555;
    tick();
    check_val("acc_we", 32'(memWe), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; ldReq = 1'b0; ldWe = 1'b0;
    check_val("rst_mid_memWe", 32'(memWe), 32'd0);
    check_val("rst_mid_ldAck", 32'(ldAck), 32'd0);
    check_val("rst_mid_ldRData", 32'(ldRData), 32'd0);
    check_val("rst_mid_cpuData", 32'(cpuData), 32'd0);
    check_val("rst_mid_cpuValid", 32'(cpuValid), 32'd0);
    check_val("rst_mid_ldErr", 32'(ldErr), 32'd0);
    check_val("rst_mid_cpuHold", 32'(cpuHold), 32'd0);
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (ldAck) acks++;
    end
    check_val("rst_mid_no_ack", 32'(acks), 32'd0);
    pre_we = 1'b1; pre_addr = 9'h020; pre_data = ref_mem[32];
    tick();
    pre_we = 1'b0;
    cpu_txn(9'h1FF, lat, rd);
    check_val("post_rst_lat", 32'(lat), 32'd3);
    check_val("post_rst_data", 32'(rd), 32'hA5C);
    tick();

`ifdef PMEM_WRITE_VERIFY_EN
    // write verify: corrupted readback flags an error, clean one does not
    corrupt_rd = 1'b1;
    ld_txn(1'b1, 9'h030, 12'hFFF, lat, err, rd);
    corrupt_rd = 1'b0;
    ref_mem[48] = 12'hFFF;
    check_val("vrfy_bad_lat", 32'(lat), 32'd4);
    check_val("vrfy_bad_err", 32'(err), 32'd1);
    tick();
    ld_txn(1'b1, 9'h031, 12'h0F0, lat, err, rd);
    ref_mem[49] = 12'h0F0;
    check_val("vrfy_ok_lat", 32'(lat), 32'd4);
    check_val("vrfy_ok_err", 32'(err), 32'd0);
    tick();
`else
    ld_txn(1'b1, 9'h030, 12'hFFF, lat, err, rd);
    ref_mem[48] = 12'hFFF;
    check_val("wr_lat", 32'(lat), 32'd2);
    check_val("wr_err", 32'(err), 32'd0);
    tick();
`endif

    // randomized traffic against the reference memory
    cpu_busy = 1'b0; ld_busy = 1'b0; ld_w = 1'b0; cpu_a = '0; ld_a = '0; ld_d = '0;
    l0 = 1'b0; l1 = 1'b0; l2 = 1'b0; r0 = 1'b0; r1 = 1'b0; r2 = 1'b0;
    run = 0; cpu_wait = 0; ld_wait = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      l2 = l1; l1 = l0; l0 = ldLock;
      r2 = r1; r1 = r0; r0 = ldReq;
      #1;
      if (cpuValid && ldAck) check_val("one_in_flight", 32'd1, 32'd0);
      if (cpuValid) begin
        check_val("rnd_cpu_busy", 32'(cpu_busy), 32'd1);
        check_val("rnd_cpu_data", 32'(cpuData), 32'(ref_mem[cpu_a]));
        check_val("rnd_lock_no_cpu", 32'(l2), 32'd0);
        if (r2) run++;
        check_val("rnd_burst_bound", 32'(run > MAXB), 32'd0);
        cpu_busy = 1'b0; cpu_wait = 0;
      end
      if (ldAck) begin
        check_val("rnd_ld_busy", 32'(ld_busy), 32'd1);
        if (ld_w) begin
          check_val("rnd_ld_err", 32'(ldErr), 32'd0);
          ref_mem[ld_a] = ld_d;
        end else begin
          check_val("rnd_ld_data", 32'(ldRData), 32'(ref_mem[ld_a]));
        end
        run = 0;
        ld_busy = 1'b0; ld_wait = 0;
      end
      if (l0) check_val("rnd_hold_lock", 32'(cpuHold), 32'd1);
      else if (!r0) check_val("rnd_hold_free", 32'(cpuHold), 32'd0);

      if (cpu_busy && !ldLock) cpu_wait++;
      if (ld_busy) ld_wait++;
      if (cpu_wait > 60 || ld_wait > 60) begin
        check_val("rnd_stall_timeout", 32'(cpu_wait + ld_wait), 32'd0);
        break;
      end

      if (!cpu_busy) begin
        if ($urandom_range(0, 3) != 0) begin
          cpu_busy = 1'b1; cpu_a = rnd_addr();
          cpuAddr = cpu_a; cpuReq = 1'b1;
        end else begin
          cpuReq = 1'b0;
        end
      end
      if (!ld_busy) begin
        if ($urandom_range(0, 2) == 0) begin
          ld_busy = 1'b1; ld_a = rnd_addr(); ld_w = 1'($urandom); ld_d = IW'($urandom);
          ldAddr = ld_a; ldWe = ld_w; ldWData = ld_d; ldReq = 1'b1;
        end else begin
          ldReq = 1'b0;
        end
      end
      if ($urandom_range(0, 24) == 0) ldLock = ~ldLock;
    end

    cpuReq = 1'b0; ldReq = 1'b0; ldLock = 1'b0;
    tick(); tick(); tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pmem_arbiter.md
PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 9, program-memory word address width.
REQ-002 SHALL have parameter INST_WIDTH, default 12, instruction word width.
REQ-003 SHALL have parameter MAX_CPU_BURST, default 4, maximum consecutive CPU grants while the loader waits.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port cpuReq  input  1  core fetch request.
REQ-007 SHALL have port cpuAddr  input  PC_WIDTH  core fetch address (the PC).
REQ-008 SHALL have port cpuData  output  INST_WIDTH  fetched instruction, registered.
REQ-009 SHALL have port cpuValid  output  1  one-cycle pulse, cpuData valid.
REQ-010 SHALL have port cpuHold  output  1  core must stall; registered.
REQ-011 SHALL have port ldLock  input  1  programming mode; loader owns memory exclusively.
REQ-012 SHALL have port ldReq  input  1  loader transaction request.
REQ-013 SHALL have port ldWe  input  1  loader write (1) or read (0).
REQ-014 SHALL have port ldAddr  input  PC_WIDTH  loader address.
REQ-015 SHALL have port ldWData  input  INST_WIDTH  loader write data.
REQ-016 SHALL have port ldRData  output  INST_WIDTH  loader read data, registered.
REQ-017 SHALL have port ldAck  output  1  one-cycle pulse, loader transaction complete.
REQ-018 SHALL have port ldErr  output  1  write-verify mismatch flag, valid with ldAck.
REQ-019 SHALL have ports memAddr (output, PC_WIDTH), memWe (output, 1), memWData (output, INST_WIDTH), memRData (input, INST_WIDTH); memory has a 1-cycle synchronous read.

Function
REQ-020 SHALL implement states IDLE, ACC, WAIT, VRFY; one transaction in flight at any time.
REQ-021 In IDLE, SHALL sample requests at each edge and latch owner, address, write flag and write data on acceptance; the next state is ACC.
REQ-022 Arbitration in IDLE SHALL be: ldLock=1 -> loader only, cpuReq ignored; otherwise CPU wins, except that ldReq wins when burstCnt==MAX_CPU_BURST.
REQ-023 burstCnt SHALL increment on each CPU grant while ldReq=1, saturate at MAX_CPU_BURST, and clear on a loader grant or on any IDLE cycle with ldReq=0.
REQ-024 In ACC, SHALL drive memAddr=latched address; memWe=1 only for a loader write; memWData=latched data; memWe=0 in all other states.
REQ-025 Read path SHALL be ACC -> WAIT -> IDLE; at the WAIT-ending edge, SHALL capture memRData into cpuData or ldRData and pulse cpuValid or ldAck.
REQ-026 A read SHALL take 2 cycles from acceptance edge to valid pulse; minimum spacing between accepted requests SHALL be 3 cycles.
REQ-027 A write with verify compiled out SHALL go ACC -> IDLE, pulsing ldAck at the ACC-ending edge, with ldErr=0.
REQ-028 ldReq handshake: loader SHALL hold ldReq/ldWe/ldAddr/ldWData stable until ldAck; ldReq still high in IDLE after ldAck SHALL be treated as a new request.
REQ-029 cpuHold SHALL be 1 while ldLock=1 or while a loader transaction is in flight; 0 otherwise.
REQ-030 If ldLock rises during a CPU transaction, that transaction SHALL complete with cpuValid before the loader is served.
REQ-031 Addresses SHALL be used unmodified; no wrap or range check (full PC_WIDTH space valid).

Reset
REQ-032 When rst=1 at an edge, SHALL go to IDLE, clear burstCnt, and set cpuData=0, ldRData=0, cpuValid=0, ldAck=0, ldErr=0, cpuHold=0.
REQ-033 Reset mid-transaction SHALL abandon it: no valid or ack pulse, and memWe=0 from the cycle after the reset edge.

Configuration
REQ-034 Macro PMEM_WRITE_VERIFY_EN: when defined, a loader write SHALL go ACC -> VRFY (re-presenting the address with memWe=0) -> WAIT, then compare memRData with the latched data; ldAck SHALL pulse with ldErr=1 on mismatch, else ldErr=0, and write latency SHALL be 3 cycles.
REQ-035 Without PMEM_WRITE_VERIFY_EN, state VRFY SHALL not exist and ldErr SHALL be tied to 0.

Verification
REQ-036 Reset, then cpuReq=1 with cpuAddr=0x1FF and memory[0x1FF]=0xA5C -> cpuValid pulse 2 cycles after acceptance, cpuData=0xA5C.
REQ-037 ldLock=1, loader writes 0x123 to 0x010, then reads 0x010 -> memWe pulse, ldAck twice, ldRData=0x123; cpuHold=1 throughout; cpuReq never granted.
REQ-038 cpuReq and ldReq held high continuously, MAX_CPU_BURST=4 -> grant order CPU, CPU, CPU, CPU, LD, repeating.
REQ-039 With PMEM_WRITE_VERIFY_EN, model forces memRData=0x000 during readback of a 0xFFF write -> ldAck with ldErr=1; a correct readback gives ldErr=0.
REQ-040 rst=1 asserted during ACC of a loader write -> memWe=0 in the next cycle, no ldAck, all outputs 0, a new cpuReq is served normally afterwards.
